// File: rtl/wb_pkg.sv
// Shared Wishbone initiator types: FSM state encoding, request field widths and a request record.
package wb_pkg;

    localparam int unsigned AdrW = 32;
    localparam int unsigned DatW = 32;
    localparam int unsigned SelW = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StActive  = 2'd1,
        StBackoff = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic            we;
        logic [AdrW-1:0] adr;
        logic [SelW-1:0] sel;
        logic [DatW-1:0] dat;
    } wb_req_t;

    function automatic logic word_aligned(input logic [AdrW-1:0] adr);
        return adr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// Core request/response and Wishbone classic bus signals of wb_initiator.
// The master modport is the initiator's view; slave is the view of the core and the bus target.
interface wb_initiator_if;
    import wb_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [AdrW-1:0] req_adr_i;
    logic [SelW-1:0] req_sel_i;
    logic [DatW-1:0] req_dat_i;

    logic            rsp_valid_o;
    logic [DatW-1:0] rsp_dat_o;
    logic            rsp_err_o;
    logic            rsp_timeout_o;

    logic            cyc_o;
    logic            stb_o;
    logic            we_o;
    logic [AdrW-1:0] adr_o;
    logic [SelW-1:0] sel_o;
    logic [DatW-1:0] dat_o;
    logic [DatW-1:0] dat_i;
    logic            ack_i;
    logic            err_i;
    logic            rty_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        output req_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );

endinterface

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator with retry backoff and misalignment rejection.
// Define WB_INITIATOR_TIMEOUT_EN to add a per-attempt timeout that fails a stalled transfer.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3
`ifdef WB_INITIATOR_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input logic            clk_i,
    input logic            rst_ni,
    wb_initiator_if.master bus
);

    localparam int unsigned RtyW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    wb_state_e       state_q;
    wb_req_t         req_q;
    logic            ready_q;
    logic            bus_q;
    logic            misalign_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [DatW-1:0] rsp_dat_q;
    logic [RtyW-1:0] rty_cnt_q;

    logic finish;
    logic fail;
    logic retry;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int unsigned TmoW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TmoW-1:0] tmo_cnt_q;
    logic            rsp_tmo_q;
    logic            tmo_fire;
`endif

    // Termination decode for the current ACTIVE cycle, priority err > rty > ack.
    always_comb begin
        finish = 1'b0;
        fail   = 1'b0;
        retry  = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        if (state_q == StActive) begin
            if (misalign_q) begin
                finish = 1'b1;
                fail   = 1'b1;
            end else if (bus.err_i) begin
                finish = 1'b1;
                fail   = 1'b1;
            end else if (bus.rty_i) begin
                if (rty_cnt_q == RtyW'(MAX_RETRY)) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end else begin
                    retry = 1'b1;
                end
            end else if (bus.ack_i) begin
                finish = 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
            end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                finish   = 1'b1;
                fail     = 1'b1;
                tmo_fire = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            req_q       <= '0;
            ready_q     <= 1'b0;
            bus_q       <= 1'b0;
            misalign_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            rty_cnt_q   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_tmo_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            rsp_tmo_q   <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (ready_q && bus.req_valid_i) begin
                        ready_q    <= 1'b0;
                        req_q      <= '{we:  bus.req_we_i,
                                        adr: bus.req_adr_i,
                                        sel: bus.req_sel_i,
                                        dat: bus.req_dat_i};
                        // A misaligned request never touches the bus; ACTIVE just reports it.
                        misalign_q <= !word_aligned(bus.req_adr_i);
                        bus_q      <= word_aligned(bus.req_adr_i);
                        rty_cnt_q  <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        tmo_cnt_q  <= '0;
`endif
                        state_q    <= StActive;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StActive: begin
                    if (finish) begin
                        bus_q       <= 1'b0;
                        misalign_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fail;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        rsp_tmo_q   <= tmo_fire;
`endif
                        if (!fail && !req_q.we) begin
                            rsp_dat_q <= bus.dat_i;
                        end
                        ready_q     <= 1'b1;
                        state_q     <= StIdle;
                    end else if (retry) begin
                        bus_q     <= 1'b0;
                        rty_cnt_q <= rty_cnt_q + 1'b1;
                        state_q   <= StBackoff;
                    end
`ifdef WB_INITIATOR_TIMEOUT_EN
                    else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                StBackoff: begin
                    bus_q   <= 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= StActive;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
    assign bus.rsp_timeout_o = rsp_tmo_q;
`else
    assign bus.rsp_timeout_o = 1'b0;
`endif

    assign bus.cyc_o = bus_q;
    assign bus.stb_o = bus_q;
    assign bus.we_o  = req_q.we;
    assign bus.adr_o = req_q.adr;
    assign bus.sel_o = req_q.sel;
    assign bus.dat_o = req_q.dat;

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning the number of rty_i retries before the transfer is failed.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles stb_o may stay unterminated (timeout build only).
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  1  core request valid.
REQ-006 req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_adr_i  input  32  byte address.
REQ-009 req_sel_i  input  4  byte lane enables.
REQ-010 req_dat_i  input  32  write data.
REQ-011 rsp_valid_o  output  1  one-cycle response pulse; no backpressure.
REQ-012 rsp_dat_o  output  32  read data; valid with rsp_valid_o.
REQ-013 rsp_err_o  output  1  transfer failed; valid with rsp_valid_o.
REQ-014 rsp_timeout_o  output  1  failure caused by timeout; valid with rsp_valid_o.
REQ-015 cyc_o, stb_o, we_o  output  1 each  Wishbone classic cycle, strobe and write enable.
REQ-016 adr_o  output  32, sel_o  output  4, dat_o  output  32  Wishbone address, select and write data.
REQ-017 dat_i  input  32, ack_i, err_i, rty_i  input  1 each  Wishbone read data and termination signals.

Function
REQ-018 SHALL implement FSM states IDLE, ACTIVE and BACKOFF; req_ready_o SHALL be high only in IDLE.
REQ-019 On acceptance at edge E0, the block SHALL register adr/sel/dat/we and drive cyc_o=stb_o=1 from E0 until termination, moving to ACTIVE.
REQ-020 In ACTIVE, terminations SHALL be sampled on each edge with priority err_i > rty_i > ack_i.
REQ-021 On ack_i, the block SHALL drive cyc_o=stb_o=0, pulse rsp_valid_o with rsp_err_o=0, capture dat_i into rsp_dat_o for reads (hold the previous value for writes), and return to IDLE, all on the same edge.
REQ-022 On err_i, the block SHALL respond as in REQ-021 but with rsp_err_o=1 and rsp_dat_o unchanged.
REQ-023 On rty_i with retry count < MAX_RETRY, the block SHALL increment the count, deassert cyc_o/stb_o for exactly one cycle (BACKOFF), then reassert them with identical address/data.
REQ-024 On rty_i with retry count = MAX_RETRY, the block SHALL fail the transfer as in REQ-022.
REQ-025 A slave with a registered ack SHALL see a request-accept-to-rsp_valid_o latency of 2 cycles; a new request SHALL be acceptable on the edge after rsp_valid_o.
REQ-026 A request with req_adr_i[1:0] != 0 SHALL produce no bus cycle and SHALL give rsp_valid_o with rsp_err_o=1 one cycle after acceptance.
REQ-027 Outputs adr_o/sel_o/dat_o/we_o SHALL remain stable while stb_o=1; dat_i SHALL be ignored except on ack_i.

Reset
REQ-028 While rst_ni=0, all outputs SHALL be 0, state SHALL be IDLE and counters SHALL be cleared, asynchronously, including mid-transfer; an in-flight transfer SHALL produce no response.

Configuration
REQ-029 With WB_INITIATOR_TIMEOUT_EN defined, an 8+-bit counter SHALL count ACTIVE cycles; when it reaches TIMEOUT_CYCLES, the transfer SHALL be failed with rsp_err_o=1 and rsp_timeout_o=1, and cyc_o/stb_o SHALL drop.
REQ-030 Without WB_INITIATOR_TIMEOUT_EN, no timeout logic SHALL exist, the block SHALL wait indefinitely, and rsp_timeout_o SHALL be tied 0.

Structure
REQ-031 State encoding and the Wishbone request/response field widths SHALL live in shared package wb_pkg.
REQ-032 The block SHALL be a single module with no sub-module; the retry and timeout counters SHALL be inline.

Verification
REQ-033 Write 0xDEADBEEF, sel 0xF, to 0x0000_1004, then read 0x0000_1004 -> rsp_dat_o=0xDEADBEEF, rsp_err_o=0, 2-cycle latency each.
REQ-034 Write 0x000000AA with sel 0x1 over 0x11223344, then read -> 0x112233AA.
REQ-035 Slave asserts rty_i twice, then ack_i -> two one-cycle gaps in stb_o, single rsp_valid_o, rsp_err_o=0; with rty_i four times -> rsp_err_o=1 after the 4th.
REQ-036 Slave asserts err_i and ack_i together -> rsp_err_o=1; request to 0x0000_1002 -> rsp_err_o=1, cyc_o never asserted.
REQ-037 Timeout build with a slave that never responds -> rsp_timeout_o=1 exactly 255 cycles after stb_o rises; rst_ni pulsed low mid-transfer -> cyc_o=0 immediately and no rsp_valid_o.
